// File: rtl/face_detect_mul_arbiter.sv
// face_detect_mul_arbiter
// Lets NUM_REQ requesters share one pipelined 16x7 unsigned multiplier.
// A round-robin arbiter picks one operand pair per cycle and drives din0/din1.
// A valid/ID tag pipeline runs in lockstep with the multiplier, and each
// product comes back on one tagged response channel. Response backpressure
// deasserts the multiplier ce, which freezes the multiplier and the tag
// pipeline together.
//
// Optional build macro FACE_DETECT_MUL_ARB_STATS_EN adds two saturating
// 32-bit counters, stat_issue_cnt and stat_stall_cnt.

module face_detect_mul_arbiter #(
    parameter int NUM_REQ = 4,   // number of requesters (2..8)
    parameter int ID_W    = 2,   // requester ID width, 2**ID_W >= NUM_REQ
    parameter int MUL_LAT = 3    // ce-enabled edges from din0/din1 to dout
) (
    input  logic                   clk,
    input  logic                   reset,

    // requester side
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [7*NUM_REQ-1:0]   req_b,

    // shared multiplier
    output logic                   mul_ce,
    output logic [15:0]            mul_din0,
    output logic [6:0]             mul_din1,
    input  logic [21:0]            mul_dout,

    // tagged response channel
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [21:0]            rsp_data,

    output logic                   busy
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    ,
    output logic [31:0]            stat_issue_cnt,
    output logic [31:0]            stat_stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MUL_LAT-1:0]           vld;       // slot occupancy, [0] is newest
    logic [MUL_LAT-1:0][ID_W-1:0] id_pipe;   // requester tag for each slot
    logic [ID_W-1:0]              last_gnt;  // most recently granted requester

    // Arbitration results
    logic [ID_W-1:0]              cand;
    logic                         cand_found;
    logic                         issue;

    // Returns (base + off) mod NUM_REQ. It assumes base < NUM_REQ and
    // off <= NUM_REQ, so one conditional subtract is enough.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int              off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Response side and pipeline enable
    // ------------------------------------------------------------------
    assign rsp_valid = vld[MUL_LAT-1];
    assign rsp_id    = id_pipe[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |vld;

    // The whole pipeline advances unless a finished result is waiting. ce is
    // forced high during reset so the multiplier datapath flushes even if a
    // stalled response is still showing.
    assign mul_ce    = reset || !rsp_valid || rsp_ready;

    // Round-robin search starting just after the last grant
    always_comb begin
        // NOTE: every variable written in this block gets a default value
        // first. If a path left a variable unassigned, synthesis would infer
        // a latch to hold its previous value.
        cand       = '0;
        cand_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!cand_found && req_valid[wrap_idx(last_gnt, off)]) begin
                cand       = wrap_idx(last_gnt, off);
                cand_found = 1'b1;
            end
        end
    end

    // Grant and operand steering. Only the candidate sees ready, and only
    // when the pipeline can move.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        issue     = cand_found && mul_ce && !reset;
        if (issue) begin
            req_ready[cand] = 1'b1;
        end
        if (cand_found) begin
            mul_din0 = req_a[16*int'(cand) +: 16];
            mul_din1 = req_b[7*int'(cand) +: 7];
        end
    end

    // Tag pipeline and round-robin pointer. All of this state holds while
    // ce is low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // slot then samples the value its neighbour had before the edge, which
        // is what makes this a shift register and not a single-cycle pass.
        if (reset) begin
            vld      <= '0;
            id_pipe  <= '0;
            last_gnt <= ID_W'(NUM_REQ - 1);
        end else if (mul_ce) begin
            vld[0]     <= issue;
            id_pipe[0] <= issue ? cand : '0;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld[i]     <= vld[i-1];
                id_pipe[i] <= id_pipe[i-1];
            end
            if (issue) begin
                last_gnt <= cand;
            end
        end
    end

`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;

    assign stat_issue_cnt = issue_cnt;
    assign stat_stall_cnt = stall_cnt;

    // Saturating counters for accepted operations and for frozen cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && (issue_cnt != 32'hFFFF_FFFF)) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (!mul_ce && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_face_detect_mul_arbiter.sv
// tb_face_detect_mul_arbiter
// Directed bench for face_detect_mul_arbiter. It contains a behavioural
// 3-stage ce-gated multiplier, a table of single-operation vectors, and
// hand-written sequences for arbitration order, backpressure and
// reset-in-flight. Expected values are hand-computed constants.
// Honours FACE_DETECT_MUL_ARB_STATS_EN when the macro is defined.

module tb_face_detect_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [7*NUM_REQ-1:0]  req_b;
    logic                  mul_ce;
    logic [15:0]           mul_din0;
    logic [6:0]            mul_din1;
    logic [21:0]           mul_dout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [21:0]           rsp_data;
    logic                  busy;
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    logic [31:0]           stat_issue_cnt;
    logic [31:0]           stat_stall_cnt;
`endif

    face_detect_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: the product reaches dout after 3 ce-enabled edges
    wire [31:0]  prod32 = 32'(mul_din0) * 32'(mul_din1);
    logic [21:0] mp0 = '0, mp1 = '0, mp2 = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            mp0 <= prod32[21:0];
            mp1 <= mp0;
            mp2 <= mp1;
        end
    end
    assign mul_dout = mp2;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [15:0] a, input logic [6:0] b);
        req_a[16*r +: 16] = a;
        req_b[7*r +: 7]   = b;
    endtask

    // One reset cycle. Called at posedge+1 and returns at posedge+1.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #3;
        check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rst_ce"},    32'(mul_ce),    32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rst_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rst_busy"},      32'(busy),      32'd0);
    endtask

    // Records grants and responses for n request cycles plus a drain period.
    // rsp_ready stays high throughout.
    int          grant_q[$];
    int          rsp_id_q[$];
    int          rsp_data_q[$];
    int          rsp_cyc_q[$];
    logic [3:0]  ever_ready;

    task automatic run_grants(input logic [3:0] mask, input bit hold, input int n);
        grant_q.delete(); rsp_id_q.delete(); rsp_data_q.delete(); rsp_cyc_q.delete();
        ever_ready = '0;
        req_valid  = mask;
        rsp_ready  = 1'b1;
        for (int cyc = 0; cyc < n + 6; cyc++) begin
            int g;
            g = -1;
            if (cyc == n) req_valid = '0;
            #3;
            ever_ready = ever_ready | req_ready;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
            if (g >= 0) grant_q.push_back(g);
            if (rsp_valid) begin
                rsp_id_q.push_back(int'(rsp_id));
                rsp_data_q.push_back(int'(rsp_data));
                rsp_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
            if (g >= 0 && !hold) req_valid[g] = 1'b0;
        end
        req_valid = '0;
    endtask

    typedef struct {
        int          r;
        logic [15:0] a;
        logic [6:0]  b;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[8];

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         next_op;
        int         rcv[$];
        logic       saw;

        tbl[0] = '{0, 16'd1000,  7'd100, 22'd100000};
        tbl[1] = '{1, 16'd65535, 7'd127, 22'd4128641};  // 0x3EFF81, low 22 bits
        tbl[2] = '{2, 16'd0,     7'd127, 22'd0};
        tbl[3] = '{3, 16'd12345, 7'd1,   22'd12345};
        tbl[4] = '{2, 16'd65535, 7'd1,   22'd65535};
        tbl[5] = '{0, 16'd256,   7'd64,  22'd16384};
        tbl[6] = '{3, 16'd40000, 7'd100, 22'd4000000};
        tbl[7] = '{1, 16'd50000, 7'd100, 22'd805696};   // 5000000 - 2**22

        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'(i + 1), 7'd2);
        req_valid = 4'b1111;
        @(posedge clk); #1;

        // All four requesters valid straight out of reset
        do_reset("init");
        run_grants(4'b1111, 1'b0, 4);
        check("all4_ngrant", 32'(grant_q.size()), 32'd4);
        check("all4_nrsp",   32'(rsp_id_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_q.size())  check($sformatf("all4_grant%0d", k), 32'(grant_q[k]), 32'(k));
            if (k < rsp_id_q.size()) begin
                check($sformatf("all4_id%0d", k),   32'(rsp_id_q[k]),   32'(k));
                check($sformatf("all4_data%0d", k), 32'(rsp_data_q[k]), 32'(2 * (k + 1)));
                check($sformatf("all4_cyc%0d", k),  32'(rsp_cyc_q[k]),  32'(3 + k));
            end
        end

        // Requesters 0 and 2 continuously valid: grants alternate
        set_op(0, 16'd7, 7'd3);
        set_op(2, 16'd9, 7'd5);
        run_grants(4'b0101, 1'b1, 8);
        check("alt_ngrant",     32'(grant_q.size()), 32'd8);
        check("alt_nrsp",       32'(rsp_id_q.size()), 32'd8);
        check("alt_no_ready13", 32'(ever_ready & 4'b1010), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_q.size())  check($sformatf("alt_grant%0d", k), 32'(grant_q[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
            if (k < rsp_id_q.size()) begin
                check($sformatf("alt_id%0d", k),   32'(rsp_id_q[k]),   (k % 2 == 0) ? 32'd0 : 32'd2);
                check($sformatf("alt_data%0d", k), 32'(rsp_data_q[k]), (k % 2 == 0) ? 32'd21 : 32'd45);
            end
        end

        // Table: one operation at a time, latency and busy release
        rsp_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            set_op(tbl[v].r, tbl[v].a, tbl[v].b);
            req_valid = '0;
            req_valid[tbl[v].r] = 1'b1;
            #3;
            check($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(1 << tbl[v].r));
            @(posedge clk); #1;
            req_valid = '0;
            for (int k = 1; k <= 3; k++) begin
                #3;
                if (k < 3) begin
                    check($sformatf("tbl%0d_early%0d", v, k), 32'(rsp_valid), 32'd0);
                end else begin
                    check($sformatf("tbl%0d_valid", v), 32'(rsp_valid), 32'd1);
                    check($sformatf("tbl%0d_id", v),    32'(rsp_id),    32'(tbl[v].r));
                    check($sformatf("tbl%0d_data", v),  32'(rsp_data),  32'(tbl[v].exp));
                end
                @(posedge clk); #1;
            end
            #3;
            check($sformatf("tbl%0d_busy_low", v), 32'(busy),      32'd0);
            check($sformatf("tbl%0d_rsp_low", v),  32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Backpressure: hold rsp_ready low for 5 cycles with 3 results in flight
        req_valid = '0;
        do_reset("bp");
        next_op = 0;
        for (int cyc = 0; cyc < 40 && rcv.size() < 6; cyc++) begin
            bit stall;
            stall     = (cyc >= 3) && (cyc <= 7);
            req_valid = (next_op < 6) ? 4'b0010 : 4'b0000;
            set_op(1, 16'(100 + next_op), 7'd3);
            rsp_ready = !stall;
            #3;
            if (stall) begin
                check($sformatf("bp_ce_c%0d", cyc),    32'(mul_ce),    32'd0);
                check($sformatf("bp_ready_c%0d", cyc), 32'(req_ready), 32'd0);
                check($sformatf("bp_id_c%0d", cyc),    32'(rsp_id),    32'd1);
                check($sformatf("bp_data_c%0d", cyc),  32'(rsp_data),  32'd300);
            end
            if (req_ready[1]) next_op++;
            if (rsp_valid && rsp_ready) rcv.push_back(int'(rsp_data));
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        check("bp_nrsp", 32'(rcv.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < rcv.size()) check($sformatf("bp_data%0d", k), 32'(rcv[k]), 32'(300 + 3 * k));
        end
        check("bp_busy_end", 32'(busy), 32'd0);
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
        check("stat_stall", stat_stall_cnt, 32'd5);
        check("stat_issue", stat_issue_cnt, 32'd6);
`endif

        // Reset one cycle after two issues discards both operations
        do_reset("mid");
        set_op(0, 16'd11, 7'd11);
        set_op(1, 16'd13, 7'd13);
        req_valid = 4'b0011;
        #3;
        check("mid_grant0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        #3;
        check("mid_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        #3;
        check("mid_busy_before", 32'(busy),      32'd1);
        check("mid_rst_ready",   32'(req_ready), 32'd0);
        check("mid_rst_ce",      32'(mul_ce),    32'd1);
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #3;
            saw = saw | rsp_valid | busy;
            @(posedge clk); #1;
        end
        check("mid_no_rsp", 32'(saw), 32'd0);
        set_op(3, 16'd500, 7'd9);
        set_op(0, 16'd2,   7'd2);
        run_grants(4'b1001, 1'b0, 2);
        check("post_ngrant", 32'(grant_q.size()), 32'd2);
        check("post_nrsp",   32'(rsp_id_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            check("post_grant0", 32'(grant_q[0]), 32'd0);
            check("post_grant1", 32'(grant_q[1]), 32'd3);
        end
        if (rsp_id_q.size() == 2) begin
            check("post_id0",   32'(rsp_id_q[0]),   32'd0);
            check("post_data0", 32'(rsp_data_q[0]), 32'd4);
            check("post_id1",   32'(rsp_id_q[1]),   32'd3);
            check("post_data1", 32'(rsp_data_q[1]), 32'd4500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
